// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and
// register-file geometry.
package alu_seq_pkg;

  localparam int NUM_REGS = 8;
  localparam int IDX_W    = 3;
  localparam int OC_W     = 4;

  localparam logic [OC_W-1:0] OC_ADD = 4'd0;
  localparam logic [OC_W-1:0] OC_SUB = 4'd1;
  localparam logic [OC_W-1:0] OC_MUL = 4'd2;
  localparam logic [OC_W-1:0] OC_DIV = 4'd3;
  localparam logic [OC_W-1:0] OC_NOT = 4'd4;
  localparam logic [OC_W-1:0] OC_XOR = 4'd5;
  localparam logic [OC_W-1:0] OC_OR  = 4'd6;
  localparam logic [OC_W-1:0] OC_AND = 4'd7;
  localparam logic [OC_W-1:0] OC_LDI = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Opcodes that are handed to the external ALU.
  function automatic logic oc_is_alu(input logic [OC_W-1:0] oc);
    return (oc <= OC_AND);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8-entry register file: two combinational read ports, one synchronous
// write port, asynchronous clear.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      ra_idx,
  output logic [DATA_WIDTH-1:0] ra_data,
  input  logic [IDX_W-1:0]      rb_idx,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wa,
  input  logic [DATA_WIDTH-1:0] wd
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_idx];
  assign rb_data = regs_q[rb_idx];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences register-to-register operations through an external
// combinational ALU, with LDI and error responses bypassing the ALU.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OC_W-1:0]       req_oc,
  input  logic [IDX_W-1:0]      req_dst,
  input  logic [IDX_W-1:0]      req_sa,
  input  logic [IDX_W-1:0]      req_sb,
  input  logic [DATA_WIDTH-1:0] req_imm,
  output logic [OC_W-1:0]       alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output state_e                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1; the offering side holds its payload stable until then.

  state_e                state_q, state_d;
  logic [OC_W-1:0]       alu_oc_q, alu_oc_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [IDX_W-1:0]      dst_q, dst_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_valid_q, rsp_valid_d;

  logic [DATA_WIDTH-1:0] ra_data;
  logic [DATA_WIDTH-1:0] rb_data;
  logic                  rf_we;
  logic [IDX_W-1:0]      rf_wa;
  logic [DATA_WIDTH-1:0] rf_wd;
  logic                  req_bad;

  alu_seq_regfile #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_idx  (req_sa),
    .ra_data (ra_data),
    .rb_idx  (req_sb),
    .rb_data (rb_data),
    .we      (rf_we),
    .wa      (rf_wa),
    .wd      (rf_wd)
  );

  // Rejected requests never reach the ALU and never write back.
  assign req_bad = !oc_is_alu(req_oc) ||
                   ((req_oc == OC_DIV) && (rb_data == '0));

  always_comb begin
    state_d     = state_q;
    alu_oc_d    = alu_oc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    dst_d       = dst_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    rf_we       = 1'b0;
    rf_wa       = req_dst;
    rf_wd       = req_imm;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_oc == OC_LDI) begin
            rf_we       = 1'b1;
            rsp_data_d  = req_imm;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else if (req_bad) begin
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            alu_oc_d = req_oc;
            alu_a_d  = ra_data;
            alu_b_d  = rb_data;
            dst_d    = req_dst;
            state_d  = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        rf_we       = 1'b1;
        rf_wa       = dst_q;
        rf_wd       = alu_f;
        rsp_data_d  = alu_f;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_oc_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      dst_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_oc_q    <= alu_oc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      dst_q       <= dst_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign alu_oc    = alu_oc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to the
// alu_* ports and hand-computed expected results.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 16;
  localparam int RSP_LIMIT = 20;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_oc;
  logic [2:0]    req_dst;
  logic [2:0]    req_sa;
  logic [2:0]    req_sb;
  logic [W-1:0]  req_imm;
  logic [3:0]    alu_oc;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_f;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  state_e        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_sequencer #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_oc    (req_oc),
    .req_dst   (req_dst),
    .req_sa    (req_sa),
    .req_sb    (req_sb),
    .req_imm   (req_imm),
    .alu_oc    (alu_oc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // Behavioural external ALU, results truncated to W bits.
  always_comb begin
    alu_f = '0;
    case (alu_oc)
      4'd0: alu_f = alu_a + alu_b;
      4'd1: alu_f = alu_a - alu_b;
      4'd2: alu_f = alu_a * alu_b;
      4'd3: alu_f = (alu_b != '0) ? alu_a / alu_b : '0;
      4'd4: alu_f = ~alu_a;
      4'd5: alu_f = alu_a ^ alu_b;
      4'd6: alu_f = alu_a | alu_b;
      4'd7: alu_f = alu_a & alu_b;
      default: alu_f = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Issue one request, wait for its response, then consume it (rsp_ready=1).
  // lat counts rising edges after acceptance until rsp_valid is seen.
  task automatic do_op(input logic [3:0] oc, input logic [2:0] dst,
                       input logic [2:0] sa, input logic [2:0] sb,
                       input logic [W-1:0] imm,
                       output logic [W-1:0] data, output logic err,
                       output int lat);
    int w;
    w = 0;
    while (!req_ready && w < RSP_LIMIT) begin
      @(posedge clk); #1; w++;
    end
    n_cmp++;
    if (w >= RSP_LIMIT) begin
      $display("FAIL req_ready_timeout: got req_ready=%0b, need 1", req_ready);
      n_fail++;
    end
    req_valid = 1'b1; req_oc = oc; req_dst = dst; req_sa = sa; req_sb = sb;
    req_imm = imm;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < RSP_LIMIT) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (lat >= RSP_LIMIT) begin
      $display("FAIL rsp_timeout: got rsp_valid=%0b, need 1", rsp_valid);
      n_fail++;
    end
    data = rsp_data;
    err  = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic read_reg(input logic [2:0] idx, output logic [W-1:0] data);
    logic e;
    int   l;
    do_op(OC_OR, idx, idx, idx, '0, data, e, l);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_oc = '0; req_dst = '0; req_sa = '0; req_sb = '0; req_imm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %0b need 1", req_ready); n_fail++; end
    n_cmp++; if (rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid: got %0b need 0", rsp_valid); n_fail++; end
    n_cmp++; if (rsp_data !== 16'h0000) begin $display("FAIL reset_rsp_data: got %h need 0000", rsp_data); n_fail++; end
    n_cmp++; if (rsp_err !== 1'b0) begin $display("FAIL reset_rsp_err: got %0b need 0", rsp_err); n_fail++; end
    n_cmp++; if (alu_oc !== 4'd0) begin $display("FAIL reset_alu_oc: got %0d need 0", alu_oc); n_fail++; end
    n_cmp++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin $display("FAIL reset_alu_ab: got %h/%h need 0000/0000", alu_a, alu_b); n_fail++; end
  endtask

  task automatic test_ldi_add();
    logic [W-1:0] d; logic e; int l;
    do_op(OC_LDI, 3'd1, 3'd0, 3'd0, 16'd7, d, e, l);
    n_cmp++; if (d !== 16'd7 || e !== 1'b0) begin $display("FAIL ldi_r1: got %h err %0b need 0007 err 0", d, e); n_fail++; end
    n_cmp++; if (l !== 0) begin $display("FAIL ldi_latency: got %0d need 0", l); n_fail++; end
    do_op(OC_LDI, 3'd2, 3'd0, 3'd0, 16'd3, d, e, l);
    n_cmp++; if (d !== 16'd3) begin $display("FAIL ldi_r2: got %h need 0003", d); n_fail++; end
    do_op(OC_ADD, 3'd3, 3'd1, 3'd2, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'd10 || e !== 1'b0) begin $display("FAIL add: got %h err %0b need 000a err 0", d, e); n_fail++; end
    n_cmp++; if (l !== 1) begin $display("FAIL add_latency: got %0d need 1", l); n_fail++; end
    n_cmp++; if (req_ready !== 1'b1) begin $display("FAIL add_next_ready: got %0b need 1", req_ready); n_fail++; end
    n_cmp++; if (alu_oc !== 4'd0 || alu_a !== 16'd7 || alu_b !== 16'd3) begin $display("FAIL add_alu_ports: got %0d %h %h need 0 0007 0003", alu_oc, alu_a, alu_b); n_fail++; end
  endtask

  task automatic test_sub_mul();
    logic [W-1:0] d; logic e; int l;
    do_op(OC_SUB, 3'd4, 3'd2, 3'd1, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'hFFFC || e !== 1'b0) begin $display("FAIL sub: got %h err %0b need fffc err 0", d, e); n_fail++; end
    do_op(OC_LDI, 3'd1, 3'd0, 3'd0, 16'h0100, d, e, l);
    n_cmp++; if (alu_oc !== 4'd1 || alu_a !== 16'd3 || alu_b !== 16'd7) begin $display("FAIL ldi_alu_hold: got %0d %h %h need 1 0003 0007", alu_oc, alu_a, alu_b); n_fail++; end
    do_op(OC_MUL, 3'd5, 3'd1, 3'd1, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'h0000 || e !== 1'b0) begin $display("FAIL mul_trunc: got %h err %0b need 0000 err 0", d, e); n_fail++; end
  endtask

  task automatic test_errors();
    logic [W-1:0] d; logic e; int l;
    do_op(OC_LDI, 3'd6, 3'd0, 3'd0, 16'h0055, d, e, l);
    do_op(OC_DIV, 3'd6, 3'd1, 3'd0, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'h0000 || e !== 1'b1) begin $display("FAIL div0: got %h err %0b need 0000 err 1", d, e); n_fail++; end
    n_cmp++; if (l !== 0) begin $display("FAIL div0_latency: got %0d need 0", l); n_fail++; end
    n_cmp++; if (alu_oc !== 4'd2) begin $display("FAIL div0_alu_hold: got %0d need 2", alu_oc); n_fail++; end
    read_reg(3'd6, d);
    n_cmp++; if (d !== 16'h0055) begin $display("FAIL div0_r6: got %h need 0055", d); n_fail++; end
    do_op(OC_DIV, 3'd7, 3'd1, 3'd2, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'h0055 || e !== 1'b0) begin $display("FAIL div: got %h err %0b need 0055 err 0", d, e); n_fail++; end
    do_op(4'd12, 3'd3, 3'd1, 3'd2, 16'h1234, d, e, l);
    n_cmp++; if (d !== 16'h0000 || e !== 1'b1) begin $display("FAIL illegal: got %h err %0b need 0000 err 1", d, e); n_fail++; end
    read_reg(3'd3, d);
    n_cmp++; if (d !== 16'd10) begin $display("FAIL illegal_r3: got %h need 000a", d); n_fail++; end
  endtask

  task automatic test_logic_ops();
    logic [W-1:0] d; logic e; int l;
    do_op(OC_ADD, 3'd2, 3'd2, 3'd2, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'd6) begin $display("FAIL dst_eq_src: got %h need 0006", d); n_fail++; end
    read_reg(3'd2, d);
    n_cmp++; if (d !== 16'd6) begin $display("FAIL dst_eq_src_r2: got %h need 0006", d); n_fail++; end
    do_op(OC_NOT, 3'd4, 3'd3, 3'd0, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'hFFF5) begin $display("FAIL not: got %h need fff5", d); n_fail++; end
    do_op(OC_XOR, 3'd5, 3'd1, 3'd2, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'h0106) begin $display("FAIL xor: got %h need 0106", d); n_fail++; end
    do_op(OC_AND, 3'd6, 3'd4, 3'd1, 16'h0, d, e, l);
    n_cmp++; if (d !== 16'h0100) begin $display("FAIL and: got %h need 0100", d); n_fail++; end
  endtask

  task automatic test_backpressure();
    int w;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_oc = OC_ADD; req_dst = 3'd7; req_sa = 3'd1; req_sb = 3'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < RSP_LIMIT) begin
      @(posedge clk); #1; w++;
    end
    n_cmp++; if (rsp_data !== 16'h010A) begin $display("FAIL bp_data: got %h need 010a", rsp_data); n_fail++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h010A || req_ready !== 1'b0) begin
        $display("FAIL bp_hold_%0d: got valid %0b data %h ready %0b need 1 010a 0", i, rsp_valid, rsp_data, req_ready);
        n_fail++;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin $display("FAIL bp_release: got valid %0b ready %0b need 0 1", rsp_valid, req_ready); n_fail++; end
  endtask

  task automatic test_reset_exec();
    logic [W-1:0] d;
    req_valid = 1'b1; req_oc = OC_ADD; req_dst = 3'd3; req_sa = 3'd1; req_sb = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (dbg_state !== ST_EXEC) begin $display("FAIL rx_in_exec: got %0d need %0d", dbg_state, ST_EXEC); n_fail++; end
    rst = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || alu_a !== 16'h0000) begin $display("FAIL rx_async: got valid %0b alu_a %h need 0 0000", rsp_valid, alu_a); n_fail++; end
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin $display("FAIL rx_ready: got %0b need 1", req_ready); n_fail++; end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin $display("FAIL rx_no_rsp: got %0b need 0", rsp_valid); n_fail++; end
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), d);
      n_cmp++; if (d !== 16'h0000) begin $display("FAIL rx_reg%0d: got %h need 0000", r, d); n_fail++; end
    end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_sub_mul();
    test_errors();
    test_logic_ops();
    test_backpressure();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
